// File: rtl/btb_bht_predictor_if.sv
// Branch predictor bus: IF lookup, EX resolve,
// flush/redirect and statistics.
interface btb_bht_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic              if_pc_dummy_unused_never;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              ex_valid;
  logic              ex_is_branch;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] ex_target;
  logic [ADDR_W-1:0] id_pc;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] miss_cnt;

  assign if_pc_dummy_unused_never = 1'b0;

  modport master (
    output if_pc,
    output ex_valid,
    output ex_is_branch,
    output ex_taken,
    output ex_pc,
    output ex_target,
    output id_pc,
    input  pred_taken,
    input  pred_target,
    input  mispredict,
    input  redirect_pc,
    input  branch_cnt,
    input  miss_cnt
  );

  modport slave (
    input  if_pc,
    input  ex_valid,
    input  ex_is_branch,
    input  ex_taken,
    input  ex_pc,
    input  ex_target,
    input  id_pc,
    output pred_taken,
    output pred_target,
    output mispredict,
    output redirect_pc,
    output branch_cnt,
    output miss_cnt
  );
endinterface

// File: rtl/btb_bht_predictor.sv
// Direct-mapped BTB with per-entry 2-bit BHT counter,
// EX-stage resolve/flush and branch statistics.
module btb_bht_predictor #(
  parameter int         ADDR_W   = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         STAT_W   = 32
) (
  input logic clk,
  input logic rst,
  btb_bht_predictor_if.slave bp
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              r_valid [N];
  logic [TAG_W-1:0]  r_tag   [N];
  logic [ADDR_W-1:0] r_tgt   [N];
  logic [1:0]        r_ctr   [N];
  logic [STAT_W-1:0] r_branch_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic              w_if_hit;
  logic [ADDR_W-1:0] w_if_seq;
  logic              w_pred_taken;

  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_ex_hit;
  logic              w_res;
  logic [ADDR_W-1:0] w_correct;
  logic              w_mispredict;
  logic [1:0]        w_ctr_cur;
  logic [1:0]        w_ctr_nxt;

  assign w_if_idx = bp.if_pc[IDX_W+1:2];
  assign w_if_tag = bp.if_pc[ADDR_W-1:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] &&
                    (r_tag[w_if_idx] == w_if_tag);
  assign w_if_seq = bp.if_pc + ADDR_W'(4);

  assign w_pred_taken = !rst && w_if_hit &&
                        r_ctr[w_if_idx][1];

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ?
                          r_tgt[w_if_idx] : w_if_seq;

  assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
  assign w_ex_tag = bp.ex_pc[ADDR_W-1:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] &&
                    (r_tag[w_ex_idx] == w_ex_tag);

  assign w_res = bp.ex_valid && bp.ex_is_branch && !rst;
  assign w_correct = bp.ex_taken ? bp.ex_target :
                     bp.ex_pc + ADDR_W'(4);
  assign w_mispredict = w_res && (bp.id_pc != w_correct);

  assign bp.mispredict  = w_mispredict;
  assign bp.redirect_pc = w_correct;
  assign bp.branch_cnt  = r_branch_cnt;
  assign bp.miss_cnt    = r_miss_cnt;

  // Saturating 2-bit counter step for the resolving entry
  always_comb begin
    w_ctr_cur = r_ctr[w_ex_idx];
    w_ctr_nxt = w_ctr_cur;
    unique case (1'b1)
      bp.ex_taken && (w_ctr_cur != 2'b11):
        w_ctr_nxt = w_ctr_cur + 2'b01;
      !bp.ex_taken && (w_ctr_cur != 2'b00):
        w_ctr_nxt = w_ctr_cur - 2'b01;
      default:
        w_ctr_nxt = w_ctr_cur;
    endcase
  end

  // Valid bits and counters: cleared on reset, trained on resolve
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_INIT;
      end
    end else if (w_res) begin
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_nxt;
      end else if (bp.ex_taken) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_ctr[w_ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target storage: never reset, written on any taken resolve
  always_ff @(posedge clk) begin
    if (w_res && bp.ex_taken) begin
      r_tag[w_ex_idx] <= w_ex_tag;
      r_tgt[w_ex_idx] <= bp.ex_target;
    end
  end

  // Saturating branch and mispredict statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_res && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (w_mispredict && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_btb_bht_predictor.sv
// Bench for btb_bht_predictor: directed vector table,
// reset corner cases and random traffic vs a table model.
module tb_btb_bht_predictor;
  localparam int SW  = 4;
  localparam int SAT = (1 << SW) - 1;

  logic clk;
  logic rst;

  btb_bht_predictor_if #(.ADDR_W(32), .STAT_W(SW)) bus ();

  btb_bht_predictor #(
    .ADDR_W(32), .IDX_W(6), .CTR_INIT(2'b01), .STAT_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  int          m_bc;
  int          m_mc;

  logic        a_pt;
  logic [31:0] a_ptgt;
  logic        a_mp;
  logic [31:0] a_rd;
  logic [31:0] a_bc;
  logic [31:0] a_mc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int mi(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    return m_valid[mi(pc)] && (m_tag[mi(pc)] == (pc >> 8));
  endfunction

  task automatic cycle(input bit r, input bit v, input bit b,
                       input bit t, input logic [31:0] epc,
                       input logic [31:0] etgt,
                       input logic [31:0] idpc,
                       input logic [31:0] ifpc);
    bit          e_pt;
    logic [31:0] e_ptgt;
    logic [31:0] cpc;
    bit          res;
    bit          e_mp;
    int          k;
    rst              = r;
    bus.ex_valid     = v;
    bus.ex_is_branch = b;
    bus.ex_taken     = t;
    bus.ex_pc        = epc;
    bus.ex_target    = etgt;
    bus.id_pc        = idpc;
    bus.if_pc        = ifpc;
    #1;
    e_pt   = !r && mhit(ifpc) && (m_ctr[mi(ifpc)] >= 2);
    e_ptgt = e_pt ? m_tgt[mi(ifpc)] : ifpc + 32'd4;
    cpc    = t ? etgt : epc + 32'd4;
    res    = !r && v && b;
    e_mp   = res && (idpc != cpc);
    a_pt   = bus.pred_taken;
    a_ptgt = bus.pred_target;
    a_mp   = bus.mispredict;
    a_rd   = bus.redirect_pc;
    chk("model pred_taken", {31'd0, a_pt}, {31'd0, e_pt});
    chk("model pred_target", a_ptgt, e_ptgt);
    chk("model mispredict", {31'd0, a_mp}, {31'd0, e_mp});
    chk("model redirect_pc", a_rd, cpc);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_bc = 0;
      m_mc = 0;
    end else if (res) begin
      if (m_bc < SAT) m_bc++;
      if (e_mp && m_mc < SAT) m_mc++;
      k = mi(epc);
      if (mhit(epc)) begin
        if (t) begin
          if (m_ctr[k] < 3) m_ctr[k]++;
          m_tgt[k] = etgt;
        end else if (m_ctr[k] > 0) begin
          m_ctr[k]--;
        end
      end else if (t) begin
        m_valid[k] = 1'b1;
        m_tag[k]   = epc >> 8;
        m_tgt[k]   = etgt;
        m_ctr[k]   = 2;
      end
    end
    @(negedge clk);
    a_bc = 32'(bus.branch_cnt);
    a_mc = 32'(bus.miss_cnt);
    chk("model branch_cnt", a_bc, 32'(m_bc));
    chk("model miss_cnt", a_mc, 32'(m_mc));
  endtask

  typedef struct {
    bit          v, b, t;
    logic [31:0] epc, etgt, idpc, ifpc;
    bit          pt;
    logic [31:0] ptgt;
    bit          mp;
    logic [31:0] rd;
    int          bc, mc;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 8) |
        ($urandom_range(0, 7) << 2) |
        $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0) p = $urandom;
    return p;
  endfunction

  initial begin
    logic [31:0] epc, etgt, idpc;
    bit t;
    tbl[0]  = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h100,
                0, 32'h104, 0, 32'h4, 0, 0};
    tbl[1]  = '{1,1,1, 32'h100, 32'h200, 32'h104, 32'h100,
                0, 32'h104, 1, 32'h200, 1, 1};
    tbl[2]  = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h100,
                1, 32'h200, 0, 32'h4, 1, 1};
    tbl[3]  = '{1,1,0, 32'h100, 32'h200, 32'h200, 32'h100,
                1, 32'h200, 1, 32'h104, 2, 2};
    tbl[4]  = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h100,
                0, 32'h104, 0, 32'h4, 2, 2};
    tbl[5]  = '{1,1,0, 32'h100, 32'h200, 32'h104, 32'h100,
                0, 32'h104, 0, 32'h104, 3, 2};
    tbl[6]  = '{1,1,1, 32'h1100, 32'h2000, 32'h1104, 32'h100,
                0, 32'h104, 1, 32'h2000, 4, 3};
    tbl[7]  = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h100,
                0, 32'h104, 0, 32'h4, 4, 3};
    tbl[8]  = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h1100,
                1, 32'h2000, 0, 32'h4, 4, 3};
    tbl[9]  = '{0,1,1, 32'h500, 32'h900, 32'h0, 32'h1100,
                1, 32'h2000, 0, 32'h900, 4, 3};
    tbl[10] = '{1,0,1, 32'h500, 32'h900, 32'h0, 32'h1100,
                1, 32'h2000, 0, 32'h900, 4, 3};
    tbl[11] = '{1,1,1, 32'h300, 32'h700, 32'h304, 32'h300,
                0, 32'h304, 1, 32'h700, 5, 4};
    tbl[12] = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h300,
                1, 32'h700, 0, 32'h4, 5, 4};
    tbl[13] = '{1,1,0, 32'hFFFFFFFC, 32'h40, 32'h40, 32'h300,
                1, 32'h700, 1, 32'h0, 6, 5};
    tbl[14] = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC,
                0, 32'h0, 0, 32'h4, 6, 5};
    tbl[15] = '{1,1,1, 32'h300, 32'h800, 32'h800, 32'h300,
                1, 32'h700, 0, 32'h800, 7, 5};
    tbl[16] = '{0,0,0, 32'h0, 32'h0, 32'h0, 32'h300,
                1, 32'h800, 0, 32'h4, 7, 5};

    cycle(1, 1, 1, 1, 32'h100, 32'h200, 32'h0, 32'h100);
    chk("rst pred_taken", {31'd0, a_pt}, 32'd0);
    chk("rst pred_target", a_ptgt, 32'h104);
    chk("rst mispredict", {31'd0, a_mp}, 32'd0);

    for (int k = 0; k < 17; k++) begin
      cycle(0, tbl[k].v, tbl[k].b, tbl[k].t, tbl[k].epc,
            tbl[k].etgt, tbl[k].idpc, tbl[k].ifpc);
      chk($sformatf("row%0d pred_taken", k),
          {31'd0, a_pt}, {31'd0, tbl[k].pt});
      chk($sformatf("row%0d pred_target", k), a_ptgt, tbl[k].ptgt);
      chk($sformatf("row%0d mispredict", k),
          {31'd0, a_mp}, {31'd0, tbl[k].mp});
      chk($sformatf("row%0d redirect", k), a_rd, tbl[k].rd);
      chk($sformatf("row%0d branch_cnt", k), a_bc, 32'(tbl[k].bc));
      chk($sformatf("row%0d miss_cnt", k), a_mc, 32'(tbl[k].mc));
    end

    cycle(1, 1, 1, 1, 32'h300, 32'h900, 32'h0, 32'h300);
    chk("midrst pred_taken", {31'd0, a_pt}, 32'd0);
    chk("midrst pred_target", a_ptgt, 32'h304);
    chk("midrst mispredict", {31'd0, a_mp}, 32'd0);
    chk("midrst branch_cnt", a_bc, 32'd0);
    chk("midrst miss_cnt", a_mc, 32'd0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h300);
    chk("postrst pred_taken", {31'd0, a_pt}, 32'd0);
    chk("postrst pred_target", a_ptgt, 32'h304);

    for (int n = 0; n < 600; n++) begin
      epc  = rpc();
      t    = $urandom_range(0, 1) == 1;
      etgt = rpc();
      if ($urandom_range(0, 1) == 1)
        idpc = t ? etgt : epc + 32'd4;
      else
        idpc = rpc();
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 5) != 0,
            t, epc, etgt, idpc, rpc());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
